// File: rtl/wb_spram_pipe.sv
// Single-port RAM behind a Wishbone B4 pipelined slave: byte-lane writes,
// registered read, LATENCY-deep response pipeline, out-of-range error
// termination and cycle-abort flushing of in-flight responses.
module wb_spram_pipe #(
  parameter int unsigned SIZE       = 'h80,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned ADR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [ADR_WIDTH-1:0]    wb_adr,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic                    wb_stall
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned SIZE_W = $clog2(SIZE);
  localparam int unsigned IDX_W  = SIZE_W - OFF_W;
  localparam int unsigned WORDS  = SIZE / BYTES;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] dat_pipe [LATENCY];
  logic [LATENCY-1:0]    ack_pipe;
  logic [LATENCY-1:0]    err_pipe;

  logic             accept_c;
  logic             in_range_c;
  logic             wr_c;
  logic             rd_c;
  logic [IDX_W-1:0] idx_c;

  // The slave never back-pressures, so every strobe inside a cycle is taken.
  assign wb_stall   = 1'b0;
  assign accept_c   = wb_cyc & wb_stb;
  assign in_range_c = wb_adr < ADR_WIDTH'(SIZE);
  assign idx_c      = wb_adr[SIZE_W-1:OFF_W];
  assign wr_c       = accept_c & in_range_c & wb_we;
  assign rd_c       = accept_c & in_range_c & ~wb_we;

  // RAM array with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wb_sel[i]) begin
          mem[idx_c][8*i +: 8] <= wb_dat_i[8*i +: 8];
        end
      end
    end
  end

  // Response flags shift toward the output; a dropped cycle kills all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pipe <= '0;
      err_pipe <= '0;
    end else if (!wb_cyc) begin
      ack_pipe <= '0;
      err_pipe <= '0;
    end else begin
      ack_pipe <= LATENCY'({ack_pipe, accept_c & in_range_c});
      err_pipe <= LATENCY'({err_pipe, accept_c & ~in_range_c});
    end
  end

  // Registered RAM read followed by LATENCY-1 plain delay stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      if (rd_c) begin
        dat_pipe[0] <= mem[idx_c];
      end
      for (int i = 1; i < LATENCY; i++) begin
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign wb_ack   = ack_pipe[LATENCY-1];
  assign wb_err   = err_pipe[LATENCY-1];
  assign wb_dat_o = dat_pipe[LATENCY-1];

endmodule

// File: tb/tb_wb_spram_pipe.sv
// Bench for wb_spram_pipe: three instances (32b/L1, 32b/L3, 64b/L4) share one
// request stream; a scoreboard per instance tracks expected response cycle,
// kind and read data.
module tb_wb_spram_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  sel32 = '0;
  logic [31:0] dat32 = '0;
  logic [7:0]  sel64 = '0;
  logic [63:0] dat64 = '0;

  logic [31:0] a_dat, b_dat;
  logic [63:0] c_dat;
  logic        a_ack, a_err, a_stall;
  logic        b_ack, b_err, b_stall;
  logic        c_ack, c_err, c_stall;

  always #5 clk = ~clk;

  wb_spram_pipe #(.SIZE('h80), .DATA_WIDTH(32), .LATENCY(1), .ADR_WIDTH(32)) u_a (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_sel(sel32), .wb_dat_i(dat32), .wb_dat_o(a_dat), .wb_ack(a_ack), .wb_err(a_err),
    .wb_stall(a_stall));
  wb_spram_pipe #(.SIZE('h80), .DATA_WIDTH(32), .LATENCY(3), .ADR_WIDTH(32)) u_b (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_sel(sel32), .wb_dat_i(dat32), .wb_dat_o(b_dat), .wb_ack(b_ack), .wb_err(b_err),
    .wb_stall(b_stall));
  wb_spram_pipe #(.SIZE('h80), .DATA_WIDTH(64), .LATENCY(4), .ADR_WIDTH(32)) u_c (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_sel(sel64), .wb_dat_i(dat64), .wb_dat_o(c_dat), .wb_ack(c_ack), .wb_err(c_err),
    .wb_stall(c_stall));

  typedef struct {
    int          due;
    bit          is_err;
    bit          is_rd;
    logic [63:0] data;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          xerr;
    logic [31:0] xdat;
  } vec_t;

  resp_t       sb [3][$];
  vec_t        tbl [$];
  logic [7:0]  m32 [128];
  logic [7:0]  m64 [128];
  int          cnt = 0;
  int          errors = 0;
  int          checks = 0;
  logic [1:0]  use_x = '0;
  bit          x_err = 1'b0;
  logic [31:0] x_dat32 = '0;
  logic [63:0] x_dat64 = '0;

  function automatic int lat(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] rd32(input logic [31:0] a);
    int b;
    logic [31:0] r;
    b = int'(a & 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m32[b+i];
    return r;
  endfunction

  function automatic logic [63:0] rd64(input logic [31:0] a);
    int b;
    logic [63:0] r;
    b = int'(a & 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m64[b+i];
    return r;
  endfunction

  task automatic fail(input string msg);
    errors++;
    $display("FAIL %s", msg);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) fail($sformatf("%s: got %h expected %h", name, act, exp));
  endtask

  // Record what every instance should answer for the request taken this edge.
  task automatic accept();
    bit    inr;
    int    b;
    resp_t e;
    inr = adr < 32'h80;
    for (int k = 0; k < 3; k++) begin
      e.due    = cnt + lat(k) - 1;
      e.is_err = !inr;
      e.is_rd  = !we;
      e.data   = '0;
      if (inr && !we) e.data = (k == 2) ? rd64(adr) : {32'h0, rd32(adr)};
      if (k < 2 && use_x[0]) begin
        e.is_err = x_err;
        e.data   = {32'h0, x_dat32};
      end
      if (k == 2 && use_x[1]) begin
        e.is_err = x_err;
        e.data   = x_dat64;
      end
      sb[k].push_back(e);
    end
    if (inr && we) begin
      b = int'(adr & 32'hFFFF_FFFC);
      for (int i = 0; i < 4; i++) if (sel32[i]) m32[b+i] = dat32[8*i +: 8];
      b = int'(adr & 32'hFFFF_FFF8);
      for (int i = 0; i < 8; i++) if (sel64[i]) m64[b+i] = dat64[8*i +: 8];
    end
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) sb[k].delete();
  endtask

  // Compare one instance's outputs against its scoreboard head.
  task automatic mon(input int k, input logic ack, input logic err, input logic [63:0] d);
    resp_t e;
    if (ack && err) begin
      checks++;
      fail($sformatf("ack_err_both[%0d]: got ack=1 err=1 required not both", k));
    end
    if (ack || err) begin
      checks++;
      if (sb[k].size() == 0) begin
        fail($sformatf("spurious_resp[%0d]: got ack=%0b err=%0b at cycle %0d required none",
                       k, ack, err, cnt));
      end else begin
        e = sb[k].pop_front();
        if (e.due != cnt || e.is_err != err)
          fail($sformatf("resp_timing[%0d]: got err=%0b at cycle %0d required err=%0b at cycle %0d",
                         k, err, cnt, e.is_err, e.due));
        else if (ack && e.is_rd) begin
          checks++;
          if (d !== e.data)
            fail($sformatf("read_data[%0d]: got %h expected %h", k, d, e.data));
        end
      end
    end else if (sb[k].size() > 0 && sb[k][0].due <= cnt) begin
      checks++;
      e = sb[k].pop_front();
      fail($sformatf("missing_resp[%0d]: got none at cycle %0d required err=%0b at cycle %0d",
                     k, cnt, e.is_err, e.due));
    end
  endtask

  // Edge-side model: count cycles, register accepted requests, apply aborts.
  initial begin
    forever begin
      @(posedge clk);
      cnt++;
      if (rst_n) begin
        if (!cyc) flush();
        else if (stb) accept();
      end
    end
  end

  // Response monitor, sampled half a cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon(0, a_ack, a_err, {32'h0, a_dat});
        mon(1, b_ack, b_err, {32'h0, b_dat});
        mon(2, c_ack, c_err, c_dat);
      end
    end
  end

  task automatic drive(input bit en, input bit w, input logic [31:0] a,
                       input logic [3:0] s32, input logic [31:0] d32,
                       input logic [7:0] s64, input logic [63:0] d64,
                       input logic [1:0] ux, input bit xe,
                       input logic [31:0] xd32, input logic [63:0] xd64);
    cyc = 1'b1; stb = en; we = w; adr = a;
    sel32 = s32; dat32 = d32; sel64 = s64; dat64 = d64;
    use_x = ux; x_err = xe; x_dat32 = xd32; x_dat64 = xd64;
  endtask

  // One request in 32-bit terms, mirrored onto the matching 64-bit lane half.
  task automatic step32(input bit en, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input bit ux, input bit xe, input logic [31:0] xd);
    @(negedge clk);
    drive(en, w, a, s, d,
          a[2] ? {s, 4'h0} : {4'h0, s},
          a[2] ? {d, 32'h0} : {32'h0, d},
          {1'b0, ux}, xe, xd, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step32(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #100000;
    fail("watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      m32[i] = '0;
      m64[i] = '0;
    end

    tbl.push_back('{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h10,  4'hF, 32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b1, 32'h20,  4'hF, 32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h20,  4'h5, 32'hAABBCCDD, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h20,  4'hF, 32'h0,        1'b0, 32'h11BB33DD});
    tbl.push_back('{1'b1, 32'h0,   4'hF, 32'h1,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h4,   4'hF, 32'h2,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h8,   4'hF, 32'h3,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'hC,   4'hF, 32'h4,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0,   4'hF, 32'h0,        1'b0, 32'h1});
    tbl.push_back('{1'b0, 32'h4,   4'hF, 32'h0,        1'b0, 32'h2});
    tbl.push_back('{1'b0, 32'h8,   4'hF, 32'h0,        1'b0, 32'h3});
    tbl.push_back('{1'b0, 32'hC,   4'hF, 32'h0,        1'b0, 32'h4});
    tbl.push_back('{1'b0, 32'h80,  4'hF, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, 32'hFC0, 4'hF, 32'h55555555, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h0,   4'hF, 32'h0,        1'b0, 32'h1});
    tbl.push_back('{1'b1, 32'h10,  4'h0, 32'hFFFFFFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h10,  4'hF, 32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b1, 32'h7C,  4'hF, 32'hCAFEF00D, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h7C,  4'hF, 32'h0,        1'b0, 32'hCAFEF00D});
    tbl.push_back('{1'b0, 32'h7D,  4'hF, 32'h0,        1'b0, 32'hCAFEF00D});
    tbl.push_back('{1'b0, 32'h7F,  4'hF, 32'h0,        1'b0, 32'hCAFEF00D});
    tbl.push_back('{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,   1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h100, 4'hF, 32'h0,        1'b1, 32'h0});

    // Reset state, including data registers.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", {61'h0, a_ack, b_ack, c_ack}, 64'h0);
    chk("reset_err", {61'h0, a_err, b_err, c_err}, 64'h0);
    chk("reset_dat_a", {32'h0, a_dat}, 64'h0);
    chk("reset_dat_b", {32'h0, b_dat}, 64'h0);
    chk("reset_dat_c", c_dat, 64'h0);
    chk("stall_tied_low", {61'h0, a_stall, b_stall, c_stall}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents everywhere so wide reads of half-written words are defined.
    for (int i = 0; i < 32; i++) step32(1'b1, 1'b1, 32'(i * 4), 4'hF, 32'h0, 1'b0, 1'b0, '0);

    foreach (tbl[i])
      step32(1'b1, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, 1'b1, tbl[i].xerr, tbl[i].xdat);
    idle(5);

    // Full-width 64-bit write followed immediately by a read of the same word.
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h8, 4'hF, 32'h89ABCDEF, 8'hFF, 64'h0123456789ABCDEF,
          2'b00, 1'b0, '0, '0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, 8'hFF, 64'h0,
          2'b11, 1'b0, 32'h89ABCDEF, 64'h0123456789ABCDEF);
    idle(5);

    // Abort: three reads, cyc dropped two edges after the last accept.
    step32(1'b1, 1'b0, 32'h0, 4'hF, '0, 1'b0, 1'b0, '0);
    step32(1'b1, 1'b0, 32'h4, 4'hF, '0, 1'b0, 1'b0, '0);
    step32(1'b1, 1'b0, 32'h10, 4'hF, '0, 1'b0, 1'b0, '0);
    idle(1);
    @(negedge clk);
    cyc = 1'b0;
    stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet_%0d", i), {60'h0, b_ack, b_err, c_ack, c_err}, 64'h0);
    end

    // Reset pulsed while responses are still in flight.
    step32(1'b1, 1'b0, 32'h0, 4'hF, '0, 1'b0, 1'b0, '0);
    step32(1'b1, 1'b0, 32'h4, 4'hF, '0, 1'b0, 1'b0, '0);
    step32(1'b1, 1'b0, 32'h8, 4'hF, '0, 1'b0, 1'b0, '0);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    flush();
    chk("midreset_ack", {61'h0, a_ack, b_ack, c_ack}, 64'h0);
    chk("midreset_err", {61'h0, a_err, b_err, c_err}, 64'h0);
    chk("midreset_dat_c", c_dat, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 4'hF, '0, 8'h0F, '0, 2'b11, 1'b0,
          32'h1, 64'h0000000200000001);
    idle(8);

    for (int k = 0; k < 3; k++)
      chk($sformatf("drained_%0d", k), 64'(sb[k].size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
